logic_gate_unit: RTL and testbench
==================================

LOGIC_GATE_UNIT -- requirements
Module: logic_gate_unit

Interface
REQ-001 The parameter list SHALL be: WIDTH, 8, operand/result bit width (>=1).
REQ-002 The parameter list SHALL be: CNT_W, 16, width of the transfer counter.
REQ-003 Ports SHALL be: clk  input  1  single clock, all flops rising-edge; one clock, reset is asynchronous and active-low.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 a  input  WIDTH  operand A.
REQ-006 b  input  WIDTH  operand B.
REQ-007 op  input  3  operation select.
REQ-008 in_valid  input  1  operands/op valid.
REQ-009 in_ready  output  1  unit can accept operands.
REQ-010 y  output  WIDTH  registered result.
REQ-011 y_zero  output  1  registered flag, high when y is all zeros.
REQ-012 out_valid  output  1  y/y_zero hold a result.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 xfer_cnt  output  CNT_W  count of completed output transfers.

Function
REQ-015 op encoding SHALL be: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDN (a & ~b), 7 PASS (y = a); bitwise over all WIDTH bits.
REQ-016 Input transfer SHALL occur on a clock edge where in_valid && in_ready; output transfer where out_valid && out_ready.
REQ-017 in_ready SHALL equal !out_valid || out_ready (combinational; one-entry output register, no bubble on back-to-back traffic).
REQ-018 Latency SHALL be exactly 1 cycle: result of an input transfer at edge N is visible on y with out_valid=1 after edge N.
REQ-019 Throughput SHALL be one result per cycle when out_ready is held high.
REQ-020 While out_valid=1 and out_ready=0, y, y_zero and out_valid SHALL hold stable.
REQ-021 Simultaneous output and input transfer SHALL replace y with the new result and keep out_valid=1.
REQ-022 Output transfer with no input transfer SHALL clear out_valid; y SHALL retain its last value.
REQ-023 xfer_cnt SHALL increment by 1 on each output transfer and wrap from 2^CNT_W-1 to 0.
REQ-024 No combinational path SHALL exist from a, b or op to any output.

Reset
REQ-025 On rst_n low, immediately and independent of clk: out_valid=0, y=0, y_zero=1, xfer_cnt=0; reduction outputs (if present) = 0.
REQ-026 Reset asserted mid-transfer SHALL discard the held result; the first transfer after deassertion SHALL be treated as fresh.
REQ-027 in_ready SHALL read 1 during and after reset (follows from out_valid=0).

Configuration
REQ-028 Macro LOGIC_GATE_UNIT_REDUCE_EN, when defined, SHALL add outputs red_and, red_or, red_xor (1 bit each), registered with y, being &y, |y, ^y of the new result.
REQ-029 Without LOGIC_GATE_UNIT_REDUCE_EN those ports and their flops SHALL not exist; all other behaviour identical.

Structure
REQ-030 A shared package logic_gate_pkg SHALL hold the op encoding constants (OP_AND ... OP_PASS) and the 3-bit op typedef.
REQ-031 The combinational op decode SHALL be a sub-module logic_gate_alu (a, b, op -> result); the top holds the handshake register and counter.

Verification
REQ-032 WIDTH=8, a=0xF0, b=0x3C, op swept 0..7 with out_ready=1 -> y = 0x30, 0xFC, 0xCC, 0xCF, 0x03, 0x33, 0xC0, 0xF0 one cycle after each input transfer.
REQ-033 a=0x0F, b=0xF0, op=AND -> y=0x00, y_zero=1; with REDUCE_EN red_and=0, red_or=0, red_xor=0.
REQ-034 Backpressure: out_ready=0 for 5 cycles after one result -> in_ready=0, y stable; second input accepted only on the edge where out_ready returns to 1, no data lost or duplicated.
REQ-035 Streaming 20 back-to-back inputs with out_ready=1 -> 20 results in order, out_valid continuous, xfer_cnt=20.
REQ-036 CNT_W=4, 17 transfers -> xfer_cnt wraps to 1.
REQ-037 rst_n pulsed low asynchronously while out_valid=1 and out_ready=0 -> out_valid=0, y=0, xfer_cnt=0 without a clock edge.

Source files
------------

// File: rtl/logic_gate_pkg.sv
// Shared definitions for the logic gate unit: the 3-bit operation select type
// and the encoding of each bitwise operation.
package logic_gate_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND  = 3'd0;
    localparam op_t OP_OR   = 3'd1;
    localparam op_t OP_XOR  = 3'd2;
    localparam op_t OP_NAND = 3'd3;
    localparam op_t OP_NOR  = 3'd4;
    localparam op_t OP_XNOR = 3'd5;
    localparam op_t OP_ANDN = 3'd6;
    localparam op_t OP_PASS = 3'd7;

endpackage

// File: rtl/logic_gate_alu.sv
// Purely combinational bitwise operation decode; the handshake register that
// captures the result lives in the top level.
module logic_gate_alu
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  op_t              i_op,
    output logic [WIDTH-1:0] o_result
);

    // Select the bitwise operation applied across all operand bits
    always_comb begin
        o_result = '0;
        case (i_op)
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_NAND: o_result = ~(i_a & i_b);
            OP_NOR:  o_result = ~(i_a | i_b);
            OP_XNOR: o_result = ~(i_a ^ i_b);
            OP_ANDN: o_result = i_a & ~i_b;
            OP_PASS: o_result = i_a;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/logic_gate_unit.sv
// Bitwise logic unit with a one-entry valid/ready output register and a
// transfer counter. Define LOGIC_GATE_UNIT_REDUCE_EN to add red_and/red_or/red_xor.
module logic_gate_unit
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] xfer_cnt
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
    ,
    output logic             red_and,
    output logic             red_or,
    output logic             red_xor
`endif
);

    logic [WIDTH-1:0] w_result;
    logic             w_in_xfer;
    logic             w_out_xfer;

    logic [WIDTH-1:0] r_y;
    logic             r_y_zero;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_xfer_cnt;

    logic_gate_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_a      (a),
        .i_b      (b),
        .i_op     (op_t'(op)),
        .o_result (w_result)
    );

    // Register may take a new operand when empty or being drained this cycle
    assign in_ready   = !r_out_valid || out_ready;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    // Result register: load on input transfer, retain data when only drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y         <= '0;
            r_y_zero    <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (w_in_xfer) begin
            r_y         <= w_result;
            r_y_zero    <= ~|w_result;
            r_out_valid <= 1'b1;
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    // Completed output transfers, wrapping naturally at the counter width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt <= '0;
        end else if (w_out_xfer) begin
            r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
        end else begin
            r_xfer_cnt <= r_xfer_cnt;
        end
    end

    assign y         = r_y;
    assign y_zero    = r_y_zero;
    assign out_valid = r_out_valid;
    assign xfer_cnt  = r_xfer_cnt;

`ifdef LOGIC_GATE_UNIT_REDUCE_EN
    logic r_red_and;
    logic r_red_or;
    logic r_red_xor;

    // Reduction flags travel with the result they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_red_and <= 1'b0;
            r_red_or  <= 1'b0;
            r_red_xor <= 1'b0;
        end else if (w_in_xfer) begin
            r_red_and <= &w_result;
            r_red_or  <= |w_result;
            r_red_xor <= ^w_result;
        end else begin
            r_red_and <= r_red_and;
        end
    end

    assign red_and = r_red_and;
    assign red_or  = r_red_or;
    assign red_xor = r_red_xor;
`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed self-checking bench for logic_gate_unit (default WIDTH=8 instance
// plus a CNT_W=4 instance for counter wrap).
module tb_logic_gate_unit;

    logic       clk;
    logic       rst_n;
    logic [7:0] a, b;
    logic [2:0] op;
    logic       in_valid, in_ready, out_valid, out_ready, y_zero;
    logic [7:0] y;
    logic [15:0] xfer_cnt;
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
    logic red_and, red_or, red_xor;
`endif

    logic [7:0] a4, b4, y4;
    logic [2:0] op4;
    logic       in_valid4, in_ready4, out_valid4, out_ready4, y_zero4;
    logic [3:0] xfer_cnt4;
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
    logic red_and4, red_or4, red_xor4;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_ops [0:7];

    logic_gate_unit #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op),
        .in_valid(in_valid), .in_ready(in_ready), .y(y), .y_zero(y_zero),
        .out_valid(out_valid), .out_ready(out_ready), .xfer_cnt(xfer_cnt)
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
        , .red_and(red_and), .red_or(red_or), .red_xor(red_xor)
`endif
    );

    logic_gate_unit #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .op(op4),
        .in_valid(in_valid4), .in_ready(in_ready4), .y(y4), .y_zero(y_zero4),
        .out_valid(out_valid4), .out_ready(out_ready4), .xfer_cnt(xfer_cnt4)
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
        , .red_and(red_and4), .red_or(red_or4), .red_xor(red_xor4)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (y !== 8'h00) begin bad++; $display("FAIL reset_y got=%h exp=00", y); end
        total++; if (y_zero !== 1'b1) begin bad++; $display("FAIL reset_y_zero got=%b exp=1", y_zero); end
        total++; if (xfer_cnt !== 16'd0) begin bad++; $display("FAIL reset_xfer_cnt got=%0d exp=0", xfer_cnt); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ops();
        out_ready = 1'b1;
        a = 8'hF0;
        b = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            in_valid = 1'b1;
            tick();
            total++; if (y !== exp_ops[i]) begin bad++; $display("FAIL op%0d_y got=%h exp=%h", i, y, exp_ops[i]); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL op%0d_out_valid got=%b exp=1", i, out_valid); end
        end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ops_drain_valid got=%b exp=0", out_valid); end
        total++; if (y !== 8'hF0) begin bad++; $display("FAIL ops_drain_y_hold got=%h exp=f0", y); end
        total++; if (xfer_cnt !== 16'd8) begin bad++; $display("FAIL ops_xfer_cnt got=%0d exp=8", xfer_cnt); end
    endtask

    task automatic test_zero();
        a = 8'h0F;
        b = 8'hF0;
        op = 3'd0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (y !== 8'h00) begin bad++; $display("FAIL zero_y got=%h exp=00", y); end
        total++; if (y_zero !== 1'b1) begin bad++; $display("FAIL zero_flag got=%b exp=1", y_zero); end
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
        total++; if ({red_and, red_or, red_xor} !== 3'b000) begin bad++; $display("FAIL zero_reduce got=%b exp=000", {red_and, red_or, red_xor}); end
`endif
        tick();
        total++; if (xfer_cnt !== 16'd9) begin bad++; $display("FAIL zero_xfer_cnt got=%0d exp=9", xfer_cnt); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        a = 8'hAA; b = 8'h55; op = 3'd1;
        in_valid = 1'b1;
        tick();
        total++; if (y !== 8'hFF) begin bad++; $display("FAIL bp_first_y got=%h exp=ff", y); end
        a = 8'hAA; b = 8'hAA; op = 3'd2;
        for (int i = 0; i < 5; i++) begin
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc%0d got=%b exp=0", i, in_ready); end
            total++; if (y !== 8'hFF || out_valid !== 1'b1 || y_zero !== 1'b0) begin bad++; $display("FAIL bp_hold cyc%0d got=%h/%b/%b exp=ff/1/0", i, y, out_valid, y_zero); end
            tick();
        end
        total++; if (xfer_cnt !== 16'd9) begin bad++; $display("FAIL bp_no_xfer got=%0d exp=9", xfer_cnt); end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_return got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (y !== 8'h00 || y_zero !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_second got=%h/%b/%b exp=00/1/1", y, y_zero, out_valid); end
        total++; if (xfer_cnt !== 16'd10) begin bad++; $display("FAIL bp_cnt_after_first got=%0d exp=10", xfer_cnt); end
        tick();
        total++; if (out_valid !== 1'b0 || xfer_cnt !== 16'd11) begin bad++; $display("FAIL bp_drain got=%b/%0d exp=0/11", out_valid, xfer_cnt); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        b = 8'h5A;
        op = 3'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = 8'(i);
            tick();
            total++; if (y !== (8'(i) ^ 8'h5A) || out_valid !== 1'b1) begin bad++; $display("FAIL stream%0d got=%h/%b exp=%h/1", i, y, out_valid, 8'(i) ^ 8'h5A); end
        end
        in_valid = 1'b0;
        tick();
        total++; if (xfer_cnt !== 16'd20 || out_valid !== 1'b0) begin bad++; $display("FAIL stream_cnt got=%0d/%b exp=20/0", xfer_cnt, out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        a = 8'hFF; b = 8'h00; op = 3'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (y !== 8'hFF || out_valid !== 1'b1) begin bad++; $display("FAIL ar_setup got=%h/%b exp=ff/1", y, out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || y !== 8'h00 || y_zero !== 1'b1) begin bad++; $display("FAIL ar_regs got=%b/%h/%b exp=0/00/1", out_valid, y, y_zero); end
        total++; if (xfer_cnt !== 16'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL ar_cnt_ready got=%0d/%b exp=0/1", xfer_cnt, in_ready); end
        rst_n = 1'b1;
        out_ready = 1'b1;
        a = 8'h3C; b = 8'h0F; op = 3'd0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (y !== 8'h0C || out_valid !== 1'b1) begin bad++; $display("FAIL ar_fresh got=%h/%b exp=0c/1", y, out_valid); end
        tick();
        total++; if (xfer_cnt !== 16'd1) begin bad++; $display("FAIL ar_fresh_cnt got=%0d exp=1", xfer_cnt); end
    endtask

    task automatic test_wrap();
        out_ready4 = 1'b1;
        a4 = 8'h11; b4 = 8'h22; op4 = 3'd1;
        in_valid4 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (i == 16) begin
                total++; if (xfer_cnt4 !== 4'd0) begin bad++; $display("FAIL wrap_at16 got=%0d exp=0", xfer_cnt4); end
            end
        end
        in_valid4 = 1'b0;
        tick();
        total++; if (xfer_cnt4 !== 4'd1 || y4 !== 8'h33) begin bad++; $display("FAIL wrap_17 got=%0d/%h exp=1/33", xfer_cnt4, y4); end
    endtask

    initial begin
        exp_ops[0] = 8'h30; exp_ops[1] = 8'hFC; exp_ops[2] = 8'hCC; exp_ops[3] = 8'hCF;
        exp_ops[4] = 8'h03; exp_ops[5] = 8'h33; exp_ops[6] = 8'hC0; exp_ops[7] = 8'hF0;
        a = 8'h00; b = 8'h00; op = 3'd0; in_valid = 1'b0; out_ready = 1'b0;
        a4 = 8'h00; b4 = 8'h00; op4 = 3'd0; in_valid4 = 1'b0; out_ready4 = 1'b0;
        test_reset();
        test_ops();
        test_zero();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
